// File: rtl/rlbp_pkg.sv
// rtl/rlbp_pkg.sv - shared types, constants and helpers for the RLBP encoder
// Purpose : FSM state enum, code/rotation widths, clockwise neighbour
//           indices and the single-step rotate-right helper.
// Ports   : none (package).
// Options : RLBP_UNIFORM_EN (used by rlbp_encoder) enables transition counting.
package rlbp_pkg;

   localparam int CODE_W  = 8;
   localparam int ROT_W   = 3;
   localparam int TRANS_W = 4;

   // Last value of the search counter: all rotations 1..CODE_W-1 examined.
   localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(CODE_W - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Neighbour bit positions, clockwise starting at top-left.
   localparam int NB_TL = 0;
   localparam int NB_TM = 1;
   localparam int NB_TR = 2;
   localparam int NB_MR = 3;
   localparam int NB_BR = 4;
   localparam int NB_BM = 5;
   localparam int NB_BL = 6;
   localparam int NB_ML = 7;

   function automatic logic [CODE_W-1:0] rotr1(input logic [CODE_W-1:0] v);
      return {v[0], v[CODE_W-1:1]};
   endfunction

endpackage

// File: rtl/rlbp_uniform.sv
// rtl/rlbp_uniform.sv - combinational circular 0/1 transition counter
// Purpose : counts bit positions i where raw[i] != raw[(i+1)%8] and flags
//           uniform patterns (at most two transitions).
// Ports   : raw_i      in  8  unrotated pattern code
//           trans_o    out 4  transition count
//           uniform_o  out 1  trans_o <= 2
module rlbp_uniform
   import rlbp_pkg::*;
(
   input  logic [CODE_W-1:0]  raw_i,
   output logic [TRANS_W-1:0] trans_o,
   output logic               uniform_o
);

   logic [CODE_W-1:0] diff;

   // Bit i of diff compares raw[i] with its circular successor raw[i+1].
   always_comb begin
      diff      = raw_i ^ rotr1(raw_i);
      trans_o   = '0;
      for (int i = 0; i < CODE_W; i++) begin
         trans_o = trans_o + TRANS_W'(diff[i]);
      end
      uniform_o = (trans_o <= TRANS_W'(2));
   end

endmodule

// File: rtl/rlbp_encoder.sv
// rtl/rlbp_encoder.sv - rotation-invariant local binary pattern encoder
// Purpose : on a rising edge of rlbp_done, snapshot the 3x3 window, form the
//           8-bit pattern code and search its 8 circular rotations for the
//           minimum; present the result on a valid/ready port.
// Ports   : clk, reset (async, active-high)
//           rlbp_done           in  upstream window-complete flag
//           q1_1 .. q3_3        in  window bits, q2_2 is the centre
//           out_ready           in  consumer accepts the result
//           out_valid           out result valid (DONE state)
//           out_code/out_rot    out minimum code and the rotation producing it
//           out_raw             out unrotated code
//           busy                out SEARCH or DONE
//           overrun             out sticky, a start edge was dropped
//           out_trans/out_uniform out transition count / uniform flag
// Options : RLBP_UNIFORM_EN adds out_trans/out_uniform and the counter.
module rlbp_encoder
   import rlbp_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                rlbp_done,
   input  logic                q1_1,
   input  logic                q1_2,
   input  logic                q1_3,
   input  logic                q2_1,
   input  logic                q2_2,
   input  logic                q2_3,
   input  logic                q3_1,
   input  logic                q3_2,
   input  logic                q3_3,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [CODE_W-1:0]   out_code,
   output logic [ROT_W-1:0]    out_rot,
   output logic [CODE_W-1:0]   out_raw,
   output logic                busy,
   output logic                overrun
`ifdef RLBP_UNIFORM_EN
   ,
   output logic [TRANS_W-1:0]  out_trans,
   output logic                out_uniform
`endif
);

   state_e              state_q, state_d;
   logic                done_q;
   logic [CODE_W-1:0]   raw_q, raw_d;
   logic [CODE_W-1:0]   rot_q, rot_d;
   logic [CODE_W-1:0]   min_q, min_d;
   logic [ROT_W-1:0]    idx_q, idx_d;
   logic [ROT_W-1:0]    cnt_q, cnt_d;
   logic                overrun_q, overrun_d;

   logic [CODE_W-1:0]   nb;
   logic [CODE_W-1:0]   raw_win;
   logic [CODE_W-1:0]   rot_next;
   logic                start;

   always_comb begin
      nb        = '0;
      nb[NB_TL] = q1_1;
      nb[NB_TM] = q1_2;
      nb[NB_TR] = q1_3;
      nb[NB_MR] = q2_3;
      nb[NB_BR] = q3_3;
      nb[NB_BM] = q3_2;
      nb[NB_BL] = q3_1;
      nb[NB_ML] = q2_1;
   end

   assign raw_win  = nb ^ {CODE_W{q2_2}};
   assign start    = rlbp_done & ~done_q;
   assign rot_next = rotr1(rot_q);

`ifdef RLBP_UNIFORM_EN
   logic [TRANS_W-1:0]  trans_q, trans_d;
   logic                uniform_q, uniform_d;
   logic [TRANS_W-1:0]  trans_win;
   logic                uniform_win;

   rlbp_uniform u_uniform (
      .raw_i     (raw_win),
      .trans_o   (trans_win),
      .uniform_o (uniform_win)
   );
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         done_q    <= 1'b0;
         raw_q     <= '0;
         rot_q     <= '0;
         min_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
`ifdef RLBP_UNIFORM_EN
         trans_q   <= '0;
         uniform_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         done_q    <= rlbp_done;
         raw_q     <= raw_d;
         rot_q     <= rot_d;
         min_q     <= min_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
`ifdef RLBP_UNIFORM_EN
         trans_q   <= trans_d;
         uniform_q <= uniform_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      raw_d     = raw_q;
      rot_d     = rot_q;
      min_d     = min_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      overrun_d = overrun_q;
`ifdef RLBP_UNIFORM_EN
      trans_d   = trans_q;
      uniform_d = uniform_q;
`endif

      // Capture is shared by IDLE and the back-to-back path out of DONE.
      if ((state_q == IDLE && start) || (state_q == DONE && out_ready && start)) begin
         state_d = SEARCH;
         raw_d   = raw_win;
         rot_d   = raw_win;
         min_d   = raw_win;
         idx_d   = '0;
         cnt_d   = '0;
`ifdef RLBP_UNIFORM_EN
         trans_d   = trans_win;
         uniform_d = uniform_win;
`endif
      end else begin
         case (state_q)
            SEARCH: begin
               if (start) overrun_d = 1'b1;
               // cnt_q counts rotations already examined; the cycle after the
               // seventh rotation is the hand-over into DONE.
               if (cnt_q == ROT_LAST) begin
                  state_d = DONE;
               end else begin
                  rot_d = rot_next;
                  cnt_d = cnt_q + 1'b1;
                  // Strict compare: ties keep the smaller rotation index.
                  if (rot_next < min_q) begin
                     min_d = rot_next;
                     idx_d = cnt_q + 1'b1;
                  end
               end
            end
            DONE: begin
               if (out_ready)  state_d   = IDLE;
               else if (start) overrun_d = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_code  = min_q;
   assign out_rot   = idx_q;
   assign out_raw   = raw_q;
   assign overrun   = overrun_q;
`ifdef RLBP_UNIFORM_EN
   assign out_trans   = trans_q;
   assign out_uniform = uniform_q;
`endif

endmodule

// File: tb/tb_rlbp_encoder.sv
// tb/tb_rlbp_encoder.sv - scoreboard bench for rlbp_encoder
module tb_rlbp_encoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       rlbp_done;
   logic       q1_1, q1_2, q1_3, q2_1, q2_2, q2_3, q3_1, q3_2, q3_3;
   logic       out_ready;
   logic       out_valid;
   logic [7:0] out_code;
   logic [2:0] out_rot;
   logic [7:0] out_raw;
   logic       busy;
   logic       overrun;
`ifdef RLBP_UNIFORM_EN
   logic [3:0] out_trans;
   logic       out_uniform;
`endif

   rlbp_encoder dut (
      .clk         (clk),
      .reset       (reset),
      .rlbp_done   (rlbp_done),
      .q1_1        (q1_1),
      .q1_2        (q1_2),
      .q1_3        (q1_3),
      .q2_1        (q2_1),
      .q2_2        (q2_2),
      .q2_3        (q2_3),
      .q3_1        (q3_1),
      .q3_2        (q3_2),
      .q3_3        (q3_3),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_code    (out_code),
      .out_rot     (out_rot),
      .out_raw     (out_raw),
      .busy        (busy),
      .overrun     (overrun)
`ifdef RLBP_UNIFORM_EN
      ,
      .out_trans   (out_trans),
      .out_uniform (out_uniform)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] raw;
      logic [7:0] code;
      logic [2:0] rot;
      logic [3:0] trans;
   } exp_t;

   typedef struct {
      logic [8:0] w;
      exp_t       e;
   } vec_t;

   exp_t sb[$];
   exp_t cur;
   int   checks = 0;
   int   errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // w bit order is row-major: w[0]=q1_1 .. w[4]=q2_2 .. w[8]=q3_3.
   task automatic set_window(input logic [8:0] w);
      {q3_3, q3_2, q3_1, q2_3, q2_2, q2_1, q1_3, q1_2, q1_1} = w;
   endtask

   function automatic exp_t model(input logic [8:0] w);
      exp_t        e;
      logic [7:0]  nb;
      logic [15:0] dbl;
      logic [7:0]  r;
      nb    = {w[3], w[6], w[7], w[8], w[5], w[2], w[1], w[0]};
      e.raw = nb ^ {8{w[4]}};
      e.code = e.raw;
      e.rot  = 3'd0;
      for (int k = 1; k < 8; k++) begin
         dbl = {e.raw, e.raw} >> k;
         r   = dbl[7:0];
         if (r < e.code) begin
            e.code = r;
            e.rot  = 3'(k);
         end
      end
      e.trans = 4'd0;
      for (int i = 0; i < 8; i++)
         if (e.raw[i] != e.raw[(i + 1) % 8]) e.trans = e.trans + 4'd1;
      return e;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drive a start edge; returns just after capture edge E.
   task automatic launch(input logic [8:0] w, input exp_t e);
      logic [8:0] junk;
      set_window(w);
      rlbp_done = 1'b1;
      sb.push_back(e);
      tick;
      rlbp_done = 1'b0;
      check_eq("busy_at_capture", busy, 1'b1);
      check_eq("valid_at_capture", out_valid, 1'b0);
      junk = 9'($urandom);
      set_window(junk);
   endtask

   task automatic wait_valid(input int exp_edges, input string tag);
      int n = 0;
      while (!out_valid && n < 40) begin
         tick;
         n++;
      end
      check_eq({tag, "_latency"}, n, exp_edges);
      if (out_valid) begin
         if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 1, 0);
         end else begin
            cur = sb.pop_front();
            check_eq({tag, "_raw"},  out_raw,  cur.raw);
            check_eq({tag, "_code"}, out_code, cur.code);
            check_eq({tag, "_rot"},  out_rot,  cur.rot);
`ifdef RLBP_UNIFORM_EN
            check_eq({tag, "_trans"},   out_trans,   cur.trans);
            check_eq({tag, "_uniform"}, out_uniform, (cur.trans <= 4'd2));
`endif
         end
      end
   endtask

   task automatic accept(input string tag);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      check_eq({tag, "_valid_after_accept"}, out_valid, 1'b0);
      check_eq({tag, "_busy_after_accept"}, busy, 1'b0);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_valid"},   out_valid, 1'b0);
      check_eq({tag, "_code"},    out_code,  8'h00);
      check_eq({tag, "_rot"},     out_rot,   3'd0);
      check_eq({tag, "_raw"},     out_raw,   8'h00);
      check_eq({tag, "_busy"},    busy,      1'b0);
      check_eq({tag, "_overrun"}, overrun,   1'b0);
`ifdef RLBP_UNIFORM_EN
      check_eq({tag, "_trans"},   out_trans,   4'd0);
      check_eq({tag, "_uniform"}, out_uniform, 1'b0);
`endif
   endtask

   vec_t dir[5];

   initial begin
      dir[0] = '{w: 9'h001, e: '{raw: 8'h01, code: 8'h01, rot: 3'd0, trans: 4'd2}};
      dir[1] = '{w: 9'h020, e: '{raw: 8'h08, code: 8'h01, rot: 3'd3, trans: 4'd2}};
      dir[2] = '{w: 9'h104, e: '{raw: 8'h14, code: 8'h05, rot: 3'd2, trans: 4'd4}};
      dir[3] = '{w: 9'h1FF, e: '{raw: 8'h00, code: 8'h00, rot: 3'd0, trans: 4'd0}};
      dir[4] = '{w: 9'h010, e: '{raw: 8'hFF, code: 8'hFF, rot: 3'd0, trans: 4'd0}};

      reset     = 1'b1;
      rlbp_done = 1'b0;
      out_ready = 1'b0;
      set_window(9'h000);
      tick;
      tick;
      check_reset_values("reset");
      reset = 1'b0;
      tick;

      // Directed patterns.
      foreach (dir[i]) begin
         launch(dir[i].w, dir[i].e);
         wait_valid(8, $sformatf("dir%0d", i));
         accept($sformatf("dir%0d", i));
      end

      // Back-to-back: accept and a new start on the same edge.
      launch(9'h020, model(9'h020));
      wait_valid(8, "b2b_first");
      out_ready = 1'b1;
      set_window(9'h104);
      rlbp_done = 1'b1;
      sb.push_back(model(9'h104));
      tick;
      out_ready = 1'b0;
      rlbp_done = 1'b0;
      check_eq("b2b_busy", busy, 1'b1);
      check_eq("b2b_valid_dropped", out_valid, 1'b0);
      check_eq("b2b_no_overrun", overrun, 1'b0);
      wait_valid(8, "b2b_second");
      accept("b2b");

      // Overrun: second start edge at E+3, then hold out_ready low.
      launch(9'h001, model(9'h001));
      tick;
      tick;
      rlbp_done = 1'b1;
      tick;
      rlbp_done = 1'b0;
      check_eq("overrun_set", overrun, 1'b1);
      wait_valid(5, "overrun_first");
      for (int c = 0; c < 5; c++) begin
         set_window(9'($urandom));
         tick;
         check_eq($sformatf("hold%0d_valid", c), out_valid, 1'b1);
         check_eq($sformatf("hold%0d_code", c), out_code, cur.code);
         check_eq($sformatf("hold%0d_rot", c), out_rot, cur.rot);
         check_eq($sformatf("hold%0d_raw", c), out_raw, cur.raw);
      end
      accept("overrun");
      check_eq("overrun_sticky", overrun, 1'b1);

      // Reset mid-search aborts and clears everything.
      launch(9'h104, model(9'h104));
      tick;
      tick;
      tick;
      reset = 1'b1;
      #1;
      check_reset_values("abort");
      sb.delete();
      tick;
      reset = 1'b0;
      begin
         int seen = 0;
         for (int c = 0; c < 12; c++) begin
            tick;
            if (out_valid || busy) seen++;
         end
         check_eq("abort_quiet", seen, 0);
      end

      // Random windows against the model.
      for (int r = 0; r < 8; r++) begin
         logic [8:0] w;
         w = 9'($urandom);
         launch(w, model(w));
         wait_valid(8, $sformatf("rnd%0d", r));
         accept($sformatf("rnd%0d", r));
      end
      check_eq("final_overrun", overrun, 1'b0);
      check_eq("final_sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rlbp_encoder.md
# rlbp_encoder

Downstream stage of the RLBP window capture block. When the upstream FSM signals that its 3×3 binary window is complete, this block does three things: it snapshots the nine window bits, forms an 8-bit local pattern code, and iteratively searches the eight circular rotations for the rotation-invariant minimum. The result is presented on a valid/ready output port to the feature consumer.

## Interface
Parameters:
- CODE_W, 8: pattern code width; fixed at 8, not user-changeable.
- ROT_W, 3: rotation index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rlbp_done  in  1  upstream window-complete flag; held high while upstream waits.
- q1_1, q1_2, q1_3, q2_1, q2_2, q2_3, q3_1, q3_2, q3_3  in  1 each  window bits, named q<row>_<col>; q2_2 is the centre.
- out_ready  in  1  consumer accepts the result.
- out_valid  out  1  result valid.
- out_code  out  8  minimum-rotation code.
- out_rot  out  3  rotation index k that produced out_code.
- out_raw  out  8  unrotated code.
- busy  out  1  high in the SEARCH or DONE state.
- overrun  out  1  sticky flag: a start edge was dropped.
- out_trans  out  4  circular 0/1 transition count (RLBP_UNIFORM_EN only).
- out_uniform  out  1  high when out_trans ≤ 2 (RLBP_UNIFORM_EN only).

## Operation
- Neighbour order is clockwise from top-left:
  - b0=q1_1, b1=q1_2, b2=q1_3, b3=q2_3, b4=q3_3, b5=q3_2, b6=q3_1, b7=q2_1.
  - raw[i] = b_i XOR q2_2.
- Start event: rlbp_done=1 while done_d=0. done_d is a register that follows rlbp_done every cycle in every state.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - On a start event, capture raw, and set rot=raw, min=raw, idx=0, cnt=0.
  - Then go to SEARCH.
- SEARCH, every cycle:
  - rot ← {rot[0], rot[7:1]} (rotate right by 1) and cnt ← cnt+1.
  - If the new rot < min (unsigned), set min ← new rot and idx ← cnt+1.
  - On a tie, min and idx are kept, so the smallest k wins.
  - After 7 SEARCH cycles (rotations 1..7 examined), go to DONE.
- DONE:
  - out_valid=1. out_code, out_rot, out_raw and out_trans/out_uniform hold steady.
  - When out_ready=1, go to IDLE.
  - If out_ready=1 and a start event occur in the same cycle, capture directly and go to SEARCH (back-to-back; not an overrun).
- A start event in SEARCH, or in DONE with out_ready=0, is dropped and sets overrun. Only reset clears overrun.
- out_code = rotr(out_raw, out_rot) always holds.

## Timing
- Reset values: out_valid=0, out_code=0, out_rot=0, out_raw=0, busy=0, overrun=0, out_trans=0, out_uniform=0, done_d=0, state=IDLE.
- Reset during SEARCH or DONE aborts immediately and discards the result.
- Latency: the capture edge is E. busy=1 from E. out_valid=1 from edge E+8, i.e. 7 SEARCH cycles plus the transition into DONE.
- Minimum initiation interval is 8 cycles (back-to-back via DONE).
- out_valid stays high until it is accepted on a clock edge with out_ready=1. Outputs must not change while out_valid=1 and out_ready=0.
- The window bits are sampled only on the capture edge; later changes are ignored.

## Configuration
- RLBP_UNIFORM_EN defined:
  - out_trans = number of i in 0..7 where raw[i] ≠ raw[(i+1)%8].
  - out_trans and out_uniform are registered at capture, alongside out_raw.
- RLBP_UNIFORM_EN undefined:
  - out_trans and out_uniform ports are absent and no transition logic is built.
  - All other behaviour is identical.

## Structure
- rlbp_pkg holds:
  - the state enum (IDLE, SEARCH, DONE);
  - CODE_W and ROT_W;
  - neighbour index constants NB_TL … NB_ML (0..7);
  - function rotr1.
- One sub-module, rlbp_uniform: combinational transition counter, instantiated only under RLBP_UNIFORM_EN.

## Test plan
- Centre 0, only q1_1=1, start pulse → raw=0x01, code=0x01, rot=0; out_valid at E+8; trans=2, uniform=1.
- Centre 0, only q2_3=1 → raw=0x08, code=0x01, rot=3.
- Centre 0, q1_3=q3_3=1 → raw=0x14, code=0x05, rot=2; trans=4, uniform=0.
- Centre 1 with all neighbours 1 → raw=0x00, code=0x00. Centre 1 with all neighbours 0 → raw=0xFF, code=0xFF, rot=0, trans=0.
- Second start edge at E+3 → overrun=1 and the first result is unaffected. Hold out_ready=0 for 5 cycles → outputs stable. Assert out_ready with a coincident start → new capture, no overrun, next valid 8 cycles later.
- Assert reset at E+4 → all outputs return to reset values immediately; no out_valid appears until the next start edge.
